// File: rtl/cache_victim_sel_if.sv
// rtl/cache_victim_sel_if.sv - victim-select request/response bundle
//
// Purpose: groups the update/lookup inputs and the victim/busy outputs of
// cache_victim_sel into one bundle.
// Ports (master drives, slave receives):
//   flush_stage, cache_en, lru_write_en, invalidate_cache : update control
//   hit_way, valid_way, way_lock_mask                      : per-way vectors
//   cache_set_tag                                          : lookup set index
//   p_adr                                                  : update set index
//   victim_way, busy                                       : slave outputs
interface cache_victim_sel_if #(
  parameter int NUMWAYS = 4,
  parameter int SETLEN  = 9
) ();
  logic               flush_stage;
  logic               cache_en;
  logic [NUMWAYS-1:0] hit_way;
  logic [NUMWAYS-1:0] valid_way;
  logic [NUMWAYS-1:0] way_lock_mask;
  logic [SETLEN-1:0]  cache_set_tag;
  logic [SETLEN-1:0]  p_adr;
  logic               lru_write_en;
  logic               invalidate_cache;
  logic [NUMWAYS-1:0] victim_way;
  logic               busy;

  modport master (
    output flush_stage, cache_en, hit_way, valid_way, way_lock_mask,
           cache_set_tag, p_adr, lru_write_en, invalidate_cache,
    input  victim_way, busy
  );

  modport slave (
    input  flush_stage, cache_en, hit_way, valid_way, way_lock_mask,
           cache_set_tag, p_adr, lru_write_en, invalidate_cache,
    output victim_way, busy
  );
endinterface

// File: rtl/cache_victim_sel.sv
// rtl/cache_victim_sel.sv - cache replacement victim selector (LFSR or round-robin)
//
// Purpose: picks a one-hot victim way per lookup. MODE 0 uses an LFSR as the
// candidate, MODE 1 a per-set round-robin pointer that a sweep can clear.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : asynchronous active-low reset
//   bus   : cache_victim_sel_if.slave (update inputs, victim_way, busy)
module cache_victim_sel #(
  parameter int NUMWAYS   = 4,
  parameter int SETLEN    = 9,
  parameter int NUMLINES  = 128,
  parameter int MODE      = 0,
  parameter int LFSRWIDTH = 4
) (
  input logic              clk,
  input logic              reset,
  cache_victim_sel_if.slave bus
);

  localparam int IW = $clog2(NUMWAYS);
  localparam int CW = (NUMLINES > 1) ? $clog2(NUMLINES) : 1;
  localparam logic [SETLEN:0] NL   = (SETLEN+1)'(NUMLINES);
  localparam logic [CW-1:0]   LAST = CW'(NUMLINES - 1);

  typedef enum logic [0:0] {IDLE, SWEEP} state_t;

  state_t               state, state_next;
  logic                 busy;
  logic [LFSRWIDTH-1:0] lfsr, lfsr_next;
  logic [7:0]           s8;
  logic                 fb;
  logic [IW-1:0]        ptr [NUMLINES];
  logic [CW-1:0]        counter;
  logic                 update;
  logic                 set_ok, padr_ok;
  logic [IW-1:0]        cand, victim_idx, probe;
  logic                 found;

  // Zero-extend so every tap position is addressable for any width.
  assign s8 = 8'(lfsr);

  always_comb begin
    fb = 1'b0;
    case (LFSRWIDTH)
      2:       fb = s8[1] ^ s8[0];
      3:       fb = s8[2] ^ s8[1];
      4:       fb = s8[3] ^ s8[2];
      5:       fb = s8[4] ^ s8[2];
      6:       fb = s8[5] ^ s8[4];
      7:       fb = s8[6] ^ s8[5];
      8:       fb = s8[7] ^ s8[5] ^ s8[4] ^ s8[3];
      default: fb = 1'b0;
    endcase
  end

  assign lfsr_next = {lfsr[LFSRWIDTH-2:0], fb};

  assign update  = bus.lru_write_en & bus.cache_en & ~bus.flush_stage &
                   ~busy & ~bus.invalidate_cache;
  // Set indices beyond NUMLINES have no pointer entry.
  assign set_ok  = ({1'b0, bus.cache_set_tag} < NL);
  assign padr_ok = ({1'b0, bus.p_adr} < NL);

  always_comb begin
    cand = '0;
    if (MODE == 0)
      cand = lfsr[IW-1:0];
    else if (!busy && set_ok)
      cand = ptr[bus.cache_set_tag[CW-1:0]];
  end

  // Descending loops so the lowest index / smallest offset wins.
  always_comb begin
    victim_idx = cand;
    found      = 1'b0;
    probe      = '0;
    for (int i = NUMWAYS - 1; i >= 0; i--) begin
      if (!bus.valid_way[i] && !bus.way_lock_mask[i]) begin
        victim_idx = IW'(i);
        found      = 1'b1;
      end
    end
    if (!found && !(&bus.way_lock_mask)) begin
      for (int k = NUMWAYS - 1; k >= 0; k--) begin
        probe = cand + IW'(k);
        if (!bus.way_lock_mask[probe])
          victim_idx = probe;
      end
    end
  end

  assign bus.victim_way = NUMWAYS'(1) << victim_idx;
  assign bus.busy       = busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state == SWEEP);
    case (state)
      IDLE:    if (MODE == 1 && bus.invalidate_cache) state_next = SWEEP;
      SWEEP:   if (!bus.invalidate_cache && counter == LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr    <= LFSRWIDTH'(1);
      counter <= '0;
      for (int i = 0; i < NUMLINES; i++)
        ptr[i] <= '0;
    end else begin
      if (update)
        lfsr <= lfsr_next;
      if (MODE == 1) begin
        if (bus.invalidate_cache)
          counter <= '0;
        else if (state == SWEEP)
          counter <= counter + 1'b1;

        if (state == SWEEP)
          ptr[counter] <= '0;
        else if (update && bus.hit_way == '0 && padr_ok)
          ptr[bus.p_adr[CW-1:0]] <= victim_idx + 1'b1;
      end
    end
  end

endmodule
